// File: rtl/dnn_pkg.sv
// Shared defaults and types for the inference-engine result path.
package dnn_pkg;

    localparam int DATA_WIDTH  = 11;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_WIDTH   = 4;

    typedef logic signed [DATA_WIDTH-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/dnn_result_argmax_if.sv
// Engine result-port and downstream result handshake seen by the argmax block.
interface dnn_result_argmax_if #(
    parameter int DATA_WIDTH = dnn_pkg::DATA_WIDTH,
    parameter int IDX_WIDTH  = dnn_pkg::IDX_WIDTH
) ();

    logic                         done;
    logic [IDX_WIDTH-1:0]         out_idx;
    logic signed [DATA_WIDTH-1:0] out;
    logic                         result_valid;
    logic                         result_ready;
    logic [IDX_WIDTH-1:0]         result_class;
    logic signed [DATA_WIDTH-1:0] result_score;
    logic                         busy;
    logic                         overrun;

    modport master (
        input  done, out, result_ready,
        output out_idx, result_valid, result_class, result_score, busy, overrun
    );

    modport slave (
        output done, out, result_ready,
        input  out_idx, result_valid, result_class, result_score, busy, overrun
    );

endinterface

// File: rtl/dnn_result_argmax_acc.sv
// Running-maximum accumulator: best score/index registers with first-load and
// strictly-greater replacement, so ties keep the lower index.
module argmax_acc #(
    parameter int DATA_WIDTH = dnn_pkg::DATA_WIDTH,
    parameter int IDX_WIDTH  = dnn_pkg::IDX_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic                         cmp_i,
    input  logic [IDX_WIDTH-1:0]         idx_i,
    input  logic signed [DATA_WIDTH-1:0] score_i,
    output logic [IDX_WIDTH-1:0]         best_idx_d_o,
    output logic signed [DATA_WIDTH-1:0] best_score_d_o
);

    logic [IDX_WIDTH-1:0]         best_idx_q, best_idx_d;
    logic signed [DATA_WIDTH-1:0] best_score_q, best_score_d;

    always_comb begin
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        if (load_i) begin
            best_idx_d   = idx_i;
            best_score_d = score_i;
        end else if (cmp_i && (score_i > best_score_q)) begin
            best_idx_d   = idx_i;
            best_score_d = score_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_idx_q   <= '0;
            best_score_q <= '0;
        end else begin
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
        end
    end

    // Next-state values let the caller capture the final winner on the last sample.
    assign best_idx_d_o   = best_idx_d;
    assign best_score_d_o = best_score_d;

endmodule

// File: rtl/dnn_result_argmax.sv
// Scans the engine's class scores after each completion edge and offers the
// winning class and score on a valid/ready handshake.
module dnn_result_argmax #(
    parameter int DATA_WIDTH  = dnn_pkg::DATA_WIDTH,
    parameter int NUM_CLASSES = dnn_pkg::NUM_CLASSES,
    parameter int IDX_WIDTH   = dnn_pkg::IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    dnn_result_argmax_if.master  bus
);
    import dnn_pkg::*;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_e                       state_q, state_d;
    logic                         done_q;
    logic [IDX_WIDTH-1:0]         out_idx_q, out_idx_d;
    logic [IDX_WIDTH-1:0]         result_class_q;
    logic signed [DATA_WIDTH-1:0] result_score_q;
    logic                         overrun_q, overrun_d;

    logic                         done_rise;
    logic                         scan_last;
    logic                         accept;
    logic [IDX_WIDTH-1:0]         acc_idx_d;
    logic signed [DATA_WIDTH-1:0] acc_score_d;

    assign done_rise = bus.done & ~done_q;
    assign scan_last = (state_q == SCAN) && (out_idx_q == LAST_IDX);
    assign accept    = (state_q == HOLD) && bus.result_ready;

    argmax_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_acc (
        .clk            (clk),
        .rst            (rst),
        .load_i         ((state_q == SCAN) && (out_idx_q == '0)),
        .cmp_i          ((state_q == SCAN) && (out_idx_q != '0)),
        .idx_i          (out_idx_q),
        .score_i        (bus.out),
        .best_idx_d_o   (acc_idx_d),
        .best_score_d_o (acc_score_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            done_q         <= 1'b0;
            out_idx_q      <= '0;
            result_class_q <= '0;
            result_score_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= bus.done;
            out_idx_q <= out_idx_d;
            overrun_q <= overrun_d;
            if (scan_last) begin
                result_class_q <= acc_idx_d;
                result_score_q <= acc_score_d;
            end
        end
    end

    // A completion edge landing on the accepting HOLD cycle restarts the scan directly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (done_rise) state_d = SCAN;
            SCAN:    if (scan_last) state_d = HOLD;
            HOLD:    if (accept)    state_d = done_rise ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_idx_d = '0;
        if ((state_q == SCAN) && !scan_last) begin
            out_idx_d = out_idx_q + IDX_WIDTH'(1);
        end
        overrun_d = overrun_q |
                    (done_rise && ((state_q == SCAN) || ((state_q == HOLD) && !accept)));
    end

    always_comb begin
        bus.result_valid = (state_q == HOLD);
        bus.busy         = (state_q != IDLE);
    end

    assign bus.out_idx      = out_idx_q;
    assign bus.result_class = result_class_q;
    assign bus.result_score = result_score_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_dnn_result_argmax.sv
// Randomised and directed scoreboard bench for the result argmax block.
module tb_dnn_result_argmax;
    import dnn_pkg::*;

    localparam int NC = NUM_CLASSES;

    typedef struct {
        int cls;
        int sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   scores [NC];
    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;

    always #5 clk = ~clk;

    dnn_result_argmax_if bus ();

    dnn_result_argmax dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Engine model: combinational score lookup by index.
    always_comb bus.out = score_t'(scores[int'(bus.out_idx) % NC]);

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget", nm);
    endtask

    // Reference: first index holding the largest value.
    function automatic exp_t ref_model();
        exp_t r;
        int   best;
        best  = scores[0];
        r.cls = 0;
        foreach (scores[i]) begin
            if (scores[i] > best) begin
                best  = scores[i];
                r.cls = i;
            end
        end
        r.sc = best;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.result_valid && bus.result_ready) begin
            exp_t e;
            n_acc++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                e = exp_q.pop_front();
                chk("result_class", int'(bus.result_class), e.cls);
                chk("result_score", int'($signed(bus.result_score)), e.sc);
            end
            $display("[TB] result accepted: class %0d score %0d", bus.result_class,
                     $signed(bus.result_score));
        end
    end

    task automatic wait_valid(input int budget, output int k, output bit seen);
        seen = 1'b0;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_scan(input int ready_delay);
        exp_t e;
        bit   seen;
        int   k;
        e = ref_model();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.result_ready = (ready_delay == 0);
        bus.done = 1'b1;
        seen = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("busy_rise", int'(bus.busy), 1);
                chk("scan_first_idx", int'(bus.out_idx), 0);
                bus.done = 1'b0;
            end
            if (bus.result_valid) begin
                seen = 1'b1;
                chk("valid_latency", k, NC + 1);
                break;
            end
        end
        if (!seen) begin
            fail_now("scan_valid");
            bus.done = 1'b0;
            return;
        end
        if (ready_delay > 0) begin
            repeat (ready_delay) begin
                @(negedge clk);
                chk("valid_held", int'(bus.result_valid), 1);
                chk("class_held", int'(bus.result_class), e.cls);
                chk("score_held", int'($signed(bus.result_score)), e.sc);
            end
            @(posedge clk);
            #1 bus.result_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("valid_drop", int'(bus.result_valid), 0);
        chk("busy_fall", int'(bus.busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k;
        bit   seen;
        int   n0;

        rst = 1'b0;
        bus.done = 1'b0;
        bus.result_ready = 1'b1;
        foreach (scores[i]) scores[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_idx", int'(bus.out_idx), 0);
        chk("rst_valid", int'(bus.result_valid), 0);
        chk("rst_class", int'(bus.result_class), 0);
        chk("rst_score", int'($signed(bus.result_score)), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Tie between indices 2 and 4.
        scores = '{5, -3, 7, 2, 7, 0, -1, 1, 6, 4};
        run_scan(0);
        chk("tc1_class", int'(bus.result_class), 2);
        chk("tc1_score", int'($signed(bus.result_score)), 7);

        foreach (scores[i]) scores[i] = -1024;
        run_scan(0);
        chk("min_class", int'(bus.result_class), 0);
        chk("min_score", int'($signed(bus.result_score)), -1024);

        foreach (scores[i]) scores[i] = -5;
        scores[NC-1] = -4;
        run_scan(1);
        chk("last_class", int'(bus.result_class), 9);
        chk("last_score", int'($signed(bus.result_score)), -4);

        // done held high for 50 cycles: a single scan.
        foreach (scores[i]) scores[i] = int'($urandom_range(0, 2047)) - 1024;
        exp_q.push_back(ref_model());
        n0 = n_acc;
        @(posedge clk);
        #1 bus.done = 1'b1;
        repeat (50) @(negedge clk);
        @(posedge clk);
        #1 bus.done = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_done_results", n_acc - n0, 1);
        chk("held_done_overrun", int'(bus.overrun), 0);
        chk("held_done_idle", int'(bus.busy), 0);

        // Back-to-back: new edge on the accepting HOLD cycle.
        foreach (scores[i]) scores[i] = int'($urandom_range(0, 2047)) - 1024;
        exp_q.push_back(ref_model());
        @(posedge clk);
        #1 bus.done = 1'b1;
        @(posedge clk);
        #1 bus.done = 1'b0;
        wait_valid(40, k, seen);
        if (!seen) fail_now("b2b_first_valid");
        foreach (scores[i]) scores[i] = int'($urandom_range(0, 6)) - 3;
        exp_q.push_back(ref_model());
        #1 bus.done = 1'b1;
        @(negedge clk);
        chk("b2b_busy", int'(bus.busy), 1);
        chk("b2b_idx0", int'(bus.out_idx), 0);
        chk("b2b_valid_low", int'(bus.result_valid), 0);
        bus.done = 1'b0;
        wait_valid(40, k, seen);
        if (!seen) fail_now("b2b_second_valid");
        else chk("b2b_latency", k + 1, NC);
        @(negedge clk);
        chk("b2b_valid_drop", int'(bus.result_valid), 0);
        chk("b2b_overrun", int'(bus.overrun), 0);

        // Stalled result with an overrun edge during the wait.
        foreach (scores[i]) scores[i] = int'($urandom_range(0, 2047)) - 1024;
        e = ref_model();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.result_ready = 1'b0;
        bus.done = 1'b1;
        @(posedge clk);
        #1 bus.done = 1'b0;
        wait_valid(40, k, seen);
        if (!seen) fail_now("stall_valid");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_valid_held", int'(bus.result_valid), 1);
            chk("stall_class", int'(bus.result_class), e.cls);
            chk("stall_score", int'($signed(bus.result_score)), e.sc);
            if (i == 5) bus.done = 1'b1;
            if (i == 7) bus.done = 1'b0;
        end
        chk("overrun_set", int'(bus.overrun), 1);
        @(posedge clk);
        #1 bus.result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_idle_valid", int'(bus.result_valid), 0);
        chk("stall_idle_busy", int'(bus.busy), 0);

        // Reset mid-scan at index 5.
        foreach (scores[i]) scores[i] = int'($urandom_range(0, 2047)) - 1024;
        exp_q.push_back(ref_model());
        @(posedge clk);
        #1 bus.done = 1'b1;
        @(posedge clk);
        #1 bus.done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy && (bus.out_idx == 4'd5)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("reach_idx5");
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_idx", int'(bus.out_idx), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_valid", int'(bus.result_valid), 0);
        chk("mid_rst_class", int'(bus.result_class), 0);
        chk("mid_rst_score", int'($signed(bus.result_score)), 0);
        chk("mid_rst_overrun", int'(bus.overrun), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", int'(bus.result_valid) + int'(bus.busy), 0);
        end
        foreach (scores[i]) scores[i] = int'($urandom_range(0, 2047)) - 1024;
        run_scan(0);

        // Randomised scans, alternating wide and tie-heavy value ranges.
        for (int it = 0; it < 16; it++) begin
            foreach (scores[i]) begin
                if (it % 2 == 0) scores[i] = int'($urandom_range(0, 2047)) - 1024;
                else             scores[i] = int'($urandom_range(0, 4)) - 1024;
            end
            run_scan(int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dnn_result_argmax.md
# dnn_result_argmax

Consumer side of the inference engine's indexed result port. After the engine signals completion, it walks `out_idx` over all class scores and reads each signed fixed-point `out` value. It keeps a running maximum and presents the winning digit and its score on a valid/ready handshake. It sits between the engine top level and whatever reports or logs the classification.

## Interface

Parameters:
- `DATA_WIDTH`, 11: width of a signed class score, matching the engine's output width.
- `NUM_CLASSES`, 10: number of scores to scan, at indices 0..NUM_CLASSES-1.
- `IDX_WIDTH`, 4: width of the index and class fields. Must satisfy 2^IDX_WIDTH >= NUM_CLASSES.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `done`, input, 1: engine completion level; a scan is triggered on its rising edge.
- `out_idx`, output, IDX_WIDTH: score select driven to the engine.
- `out`, input, DATA_WIDTH, signed: score selected by `out_idx`. The engine drives it combinationally, so it is valid in the same cycle `out_idx` is driven.
- `result_valid`, output, 1: result held and offered to the downstream block.
- `result_ready`, input, 1: downstream accepts the result.
- `result_class`, output, IDX_WIDTH: index of the winning class.
- `result_score`, output, DATA_WIDTH, signed: score of the winning class.
- `busy`, output, 1: high while in SCAN or HOLD.
- `overrun`, output, 1: sticky flag; a `done` rising edge arrived while a scan or result was still pending.

## Operation

- Reset values: state IDLE; `out_idx`=0; `result_valid`=0; `result_class`=0; `result_score`=0; `busy`=0; `overrun`=0; registered copy `done_q`=0.
- A rising edge of `done` means `done`=1 and `done_q`=0 in the same cycle.
  - A level held high does not retrigger.
  - If `done` is already high when reset is released, that counts as one edge.
- FSM states are IDLE, SCAN and HOLD.
  - IDLE to SCAN on a `done` rising edge; `out_idx` loads 0.
  - In SCAN, each cycle samples `out` for the current `out_idx`, then increments `out_idx`.
  - After sampling index NUM_CLASSES-1, SCAN goes to HOLD and `out_idx` returns to 0.
  - HOLD to IDLE when `result_valid` and `result_ready` are both high.
  - If a `done` rising edge coincides with that HOLD acceptance, go directly to SCAN instead of IDLE.
- Running maximum:
  - At index 0, load best score and best index = (`out`, 0) unconditionally.
  - At later indices, replace only if `out` is greater than best, using a signed comparison.
  - Ties keep the lower index.
  - Comparison is full-width signed with no saturation or truncation. The most negative value (-1024 for width 11) is handled like any other value.
- `result_class` and `result_score` are updated only on entry to HOLD. They stay stable through HOLD and after acceptance, until the next HOLD entry.
- `result_valid` is high exactly while in HOLD. Once asserted, it and the result data are held until accepted.
- `overrun` sets on a `done` rising edge seen in SCAN, or in HOLD without same-cycle acceptance. That edge is otherwise ignored. The flag clears only on reset.
- Asserting reset mid-scan or mid-HOLD forces all reset values immediately and discards the partial result.

## Timing

- Cycle T: the `done` rising edge is seen. Cycles T+1 through T+NUM_CLASSES are SCAN, with `out_idx` = 0..NUM_CLASSES-1.
- `result_valid` rises at T+NUM_CLASSES+1, which is T+11 by default.
- With `result_ready` held high, `result_valid` is high for exactly one cycle.
- Back-to-back scans through the direct HOLD-to-SCAN path need no idle cycle.
- `busy` rises at T+1 and falls on the cycle after acceptance.
- `out_idx` is registered and driven directly from a flop.

## Structure

- Shared package `dnn_pkg` holds:
  - `DATA_WIDTH`, `NUM_CLASSES` and `IDX_WIDTH` defaults;
  - the score typedef `logic signed [DATA_WIDTH-1:0]`;
  - the state enum (IDLE, SCAN, HOLD).
- One sub-module is natural: `argmax_acc`. It holds the best-score and best-index registers with load/compare enables and the tie rule.
- The FSM, edge detect and handshake stay in the top level of this block.

## Test plan

- Engine model returns scores {5,-3,7,2,7,0,-1,1,6,4}; pulse `done`; `result_ready`=1. Required: `result_class`=2, `result_score`=7 (tie with index 4 keeps the lower index), with `result_valid` at T+11 for one cycle.
- All scores -1024: required `result_class`=0, `result_score`=-1024. Scores all -5 except index 9 = -4: required class 9, score -4.
- `result_ready`=0 for 20 cycles after `result_valid`. Required: valid and data held stable; a second `done` edge during the wait sets `overrun`=1; after acceptance, state is IDLE.
- `done` held high for 50 cycles: exactly one scan and one result; `overrun` stays 0.
- A new `done` edge in the same cycle as HOLD acceptance: the next scan starts at T+1 with `out_idx`=0 and `overrun` stays 0.
- Assert `rst` low at SCAN index 5, release after 3 cycles with `done` low. Required: all outputs at reset values and no `result_valid`, until a fresh `done` edge produces the correct full-scan result.
